io_bus_pio: RTL
===============

Name: io_bus_pio

Overview:
Parametrised multi-channel parallel-I/O slave on the CPU's external IO bus (acknowledge / bus_enable / rw / byte_enable / address / write_data / read_data / irq).
- Each channel provides:
  - an output data register;
  - a synchronised input port;
  - rising-edge capture of the input;
  - a per-bit interrupt mask.
- Adds configurable wait states and a level interrupt to the CPU, which the current bare bus hookup lacks.
- Sits directly on the IO bus between the CPU system and board-level I/O.

Parameters:
- DATA_W, 16, bus and channel data width; multiple of 8.
- ADDR_W, 12, IO bus byte-address width.
- NUM_CH, 4, number of PIO channels; 1..64.
- WAIT_CYCLES, 1, wait states inserted before acknowledge; 0..15.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- bus_enable, in, 1, master request; held high until acknowledge is seen.
- address, in, ADDR_W, byte address.
- rw, in, 1, 1 = read, 0 = write.
- byte_enable, in, DATA_W/8, byte lane enables for writes.
- write_data, in, DATA_W, write data.
- read_data, out, DATA_W, read data; valid in the acknowledge cycle.
- acknowledge, out, 1, one-cycle transfer-complete pulse.
- irq, out, 1, level interrupt to the CPU.
- pio_in, in, NUM_CH*DATA_W, asynchronous inputs; channel c occupies bits [c*DATA_W +: DATA_W].
- pio_out, out, NUM_CH*DATA_W, registered outputs.

Behaviour:
- Reset (asynchronous, any state):
  - FSM returns to IDLE; an in-flight transfer is abandoned with no register update.
  - acknowledge=0, read_data=0, irq=0, pio_out=0.
  - All OUT, MASK and EDGE registers are 0; input synchronisers are cleared.
- Address decode:
  - word = address[ADDR_W-1:1]; address[0] is ignored.
  - reg = word[1:0]; ch = word[ADDR_W-2:2].
  - Register map: 0 OUT (RW), 1 IN (RO), 2 MASK (RW), 3 EDGE (read; write-1-to-clear).
  - ch >= NUM_CH: read returns 0, write has no effect, and the transfer is still acknowledged. The bus never hangs.
- FSM states and transitions:
  - IDLE -> WAIT when bus_enable=1. address, rw, byte_enable and write_data are latched on this edge.
  - WAIT counts WAIT_CYCLES cycles, then -> ACK. With WAIT_CYCLES=0, IDLE goes directly to ACK.
  - ACK lasts one cycle:
    - acknowledge=1;
    - on a read, read_data holds the addressed register;
    - on a write, the register updates on the clock edge that ends ACK.
  - ACK -> DONE. DONE waits for bus_enable=0, then -> IDLE. A held bus_enable never produces a second acknowledge.
- Latency: acknowledge rises WAIT_CYCLES+1 cycles after the edge that samples bus_enable=1.
- read_data returns to 0 outside the ACK cycle.
- Byte enables:
  - A write updates lane b only where byte_enable[b]=1.
  - byte_enable=0 on a write: acknowledged, no update.
  - byte_enable is ignored on reads.
- Inputs and edge capture:
  - pio_in passes through a 2-flop synchroniser; IN reads the synchronised value.
  - EDGE bit sets on a 0->1 transition of the synchronised bit.
  - Writing 1 to an EDGE bit clears it. If a new edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays 1.
- Interrupt:
  - irq = OR over all channels of |(EDGE & MASK), registered: one cycle after the EDGE/MASK change.
  - Writing MASK=0 deasserts irq on the following cycle without clearing EDGE.
- Writes to IN are ignored and still acknowledged.

Decomposition:
- Package io_bus_pkg holds:
  - the FSM state enum (IDLE, WAIT, ACK, DONE);
  - register offset constants (REG_OUT=0, REG_IN=1, REG_MASK=2, REG_EDGE=3);
  - a lane-merge function (old, new, byte_enable).
- Sub-module io_pio_channel (one instance per channel via generate) contains:
  - the synchroniser;
  - the OUT, MASK and EDGE registers;
  - edge detection;
  - a per-channel irq term;
  - a write-strobe input and a register-select input.
- io_bus_pio owns the bus FSM, the wait counter, the read mux and the irq OR.

Test Plan:
- Write then read, WAIT_CYCLES=1:
  - Write 0xBEEF to ch2 OUT (address 0x010), all lanes -> acknowledge pulses exactly 2 cycles after request; pio_out[47:32]=0xBEEF.
  - Read 0x010 -> read_data=0xBEEF in the ack cycle.
- Byte lanes: OUT=0xBEEF, write 0x1234 with byte_enable=2'b01 -> OUT=0xBE34.
- Edge and irq:
  - MASK ch0=0x0001; drive pio_in[0] 0->1 -> EDGE ch0=0x0001 after the synchroniser plus 1 cycle; irq=1 on the next cycle.
  - Write 0x0001 to EDGE -> irq=0.
- Clear/edge collision: a new rising edge on bit 3 in the same cycle as a W1C of bit 3 -> EDGE bit 3 remains 1.
- Out-of-range and held request:
  - Read ch 63 with NUM_CH=4 -> read_data=0 and acknowledged.
  - Hold bus_enable 10 cycles -> exactly one acknowledge pulse.
- Reset mid-operation: assert reset_n=0 during WAIT of a write of 0x5555 -> no acknowledge; OUT=0; after release the FSM is in IDLE and the next transfer completes normally.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and helpers for the IO-bus parallel-I/O slave: bus FSM states,
// register offsets within a channel's four-word window, and byte-lane merging.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } bus_state_e;

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_IN   = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  function automatic logic [7:0] lane_merge(input logic [7:0] old_v,
                                            input logic [7:0] new_v,
                                            input logic       be);
    return be ? new_v : old_v;
  endfunction

endpackage

// File: rtl/io_pio_channel.sv
// One PIO channel: input synchroniser, rising-edge capture, and the OUT, MASK
// and EDGE registers written through a single strobe plus register select.
module io_pio_channel
  import io_bus_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DATA_W-1:0]   pio_i,
  input  logic                wr_stb_i,
  input  logic [1:0]          reg_sel_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   out_o,
  output logic [DATA_W-1:0]   in_o,
  output logic [DATA_W-1:0]   mask_o,
  output logic [DATA_W-1:0]   edge_o,
  output logic                irq_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] sync1_q, sync2_q, prev_q;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] clr, rise;

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    clr    = '0;
    for (int b = 0; b < NB; b++) begin
      if (wr_stb_i && reg_sel_i == REG_OUT)
        out_d[b*8 +: 8] = lane_merge(out_q[b*8 +: 8], wdata_i[b*8 +: 8], be_i[b]);
      if (wr_stb_i && reg_sel_i == REG_MASK)
        mask_d[b*8 +: 8] = lane_merge(mask_q[b*8 +: 8], wdata_i[b*8 +: 8], be_i[b]);
      if (wr_stb_i && reg_sel_i == REG_EDGE)
        clr[b*8 +: 8] = lane_merge(8'h00, wdata_i[b*8 +: 8], be_i[b]);
    end
    rise = sync2_q & ~prev_q;
    // A fresh edge overrides a simultaneous write-1-to-clear.
    edge_d = (edge_q & ~clr) | rise;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      out_q   <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= pio_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      out_q   <= out_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
    end
  end

  assign out_o  = out_q;
  assign in_o   = sync2_q;
  assign mask_o = mask_q;
  assign edge_o = edge_q;
  assign irq_o  = |(edge_q & mask_q);

endmodule

// File: rtl/io_bus_pio.sv
// IO-bus PIO slave: bus handshake FSM with wait states, address decode,
// read mux across channels and a registered level interrupt.
module io_bus_pio
  import io_bus_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int NUM_CH      = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     bus_enable,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     rw,
  input  logic [DATA_W/8-1:0]      byte_enable,
  input  logic [DATA_W-1:0]        write_data,
  output logic [DATA_W-1:0]        read_data,
  output logic                     acknowledge,
  output logic                     irq,
  input  logic [NUM_CH*DATA_W-1:0] pio_in,
  output logic [NUM_CH*DATA_W-1:0] pio_out
);

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  bus_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       capture;

  logic [ADDR_W-2:0]   word_q;
  logic                rw_q;
  logic [DATA_W/8-1:0] be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                irq_q;

  logic [1:0]        reg_sel;
  logic [ADDR_W-4:0] ch_sel;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_addr_lsb;

  logic [DATA_W-1:0] ch_out  [NUM_CH];
  logic [DATA_W-1:0] ch_in   [NUM_CH];
  logic [DATA_W-1:0] ch_mask [NUM_CH];
  logic [DATA_W-1:0] ch_edge [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;
  logic [NUM_CH-1:0] ch_wr;

  assign unused_addr_lsb = address[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_enable) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACK:     state_d = DONE;
      // Master keeps bus_enable high until it sees acknowledge; wait for release.
      DONE:    if (!bus_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= |ch_irq;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      word_q  <= address[ADDR_W-1:1];
      rw_q    <= rw;
      be_q    <= byte_enable;
      wdata_q <= write_data;
    end
  end

  assign reg_sel = word_q[1:0];
  assign ch_sel  = word_q[ADDR_W-2:2];

  // Unmatched channel numbers fall through: read 0, no write strobe.
  always_comb begin
    rd_mux = '0;
    ch_wr  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (32'(ch_sel) == 32'(c)) begin
        ch_wr[c] = (state_q == ACK) && !rw_q;
        case (reg_sel)
          REG_OUT:  rd_mux = ch_out[c];
          REG_IN:   rd_mux = ch_in[c];
          REG_MASK: rd_mux = ch_mask[c];
          default:  rd_mux = ch_edge[c];
        endcase
      end
    end
  end

  assign acknowledge = (state_q == ACK);
  assign read_data   = (state_q == ACK && rw_q) ? rd_mux : '0;
  assign irq         = irq_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    io_pio_channel #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .pio_i     (pio_in[c*DATA_W +: DATA_W]),
      .wr_stb_i  (ch_wr[c]),
      .reg_sel_i (reg_sel),
      .wdata_i   (wdata_q),
      .be_i      (be_q),
      .out_o     (ch_out[c]),
      .in_o      (ch_in[c]),
      .mask_o    (ch_mask[c]),
      .edge_o    (ch_edge[c]),
      .irq_o     (ch_irq[c])
    );
    assign pio_out[c*DATA_W +: DATA_W] = ch_out[c];
  end

endmodule
